multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 279 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I-style control FSM with memory wait/timeout and sticky traps
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset; also gates every output to 0 combinationally
//   opcode       instr[6:0] from the external IR, captured during DECODE
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request valid (FETCH, MEM)
//   mem_we       request is a write (store in MEM)
//   iord         address select: 0 = PC, 1 = ALU result
//   ir_write     load IR (FETCH with mem_ready)
//   pc_write     update PC
//   branch       conditional PC update, qualified by the datapath compare
//   alu_src_1    ALU A select: 0 = rs1, 1 = PC
//   alu_src_2    ALU B select: 0 = rs2, 1 = imm
//   alu_op       ALU control class
//   mem_to_reg   writeback source: 00 ALU, 01 mem, 11 PC+4
//   reg_write    register file write
//   next_pc_sel  00 seq/branch, 01 JAL, 10 JALR
//   retire       one-cycle pulse per completed instruction
//   illegal      sticky illegal-opcode flag
//   bus_error    sticky memory-timeout flag
//   state        current FSM state (debug)

module multicycle_control #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       alu_src_1,
  output logic       alu_src_2,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [1:0] next_pc_sel,
  output logic       retire,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [6:0] opc_q;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_error_q, bus_error_d;

  // Decoded attributes of the captured opcode
  logic       is_load, is_store, is_branch, is_jal, is_jalr;
  logic       ex_src_1, ex_src_2;
  logic [1:0] ex_op;
  logic       opcode_legal;

  // Unqualified outputs before the reset gate
  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c, branch_c;
  logic       alu_src_1_c, alu_src_2_c, reg_write_c, retire_c;
  logic [1:0] alu_op_c, mem_to_reg_c, next_pc_sel_c;

  // Legality is judged on the live opcode, since DECODE is the capture cycle
  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    ex_src_1  = 1'b0;
    ex_src_2  = 1'b0;
    ex_op     = 2'b00;
    case (opc_q)
      OP_R:     ex_op = 2'b10;
      OP_I:     begin ex_src_2 = 1'b1; ex_op = 2'b10; end
      OP_LOAD:  begin is_load  = 1'b1; ex_src_2 = 1'b1; end
      OP_STORE: begin is_store = 1'b1; ex_src_2 = 1'b1; end
      OP_BR:    begin is_branch = 1'b1; ex_op = 2'b01; end
      OP_JAL:   begin is_jal = 1'b1; ex_op = 2'b11; end
      OP_JALR:  begin is_jalr = 1'b1; ex_src_2 = 1'b1; ex_op = 2'b11; end
      OP_LUI:   begin ex_src_2 = 1'b1; ex_op = 2'b11; end
      OP_AUIPC: begin ex_src_1 = 1'b1; ex_src_2 = 1'b1; ex_op = 2'b11; end
      default:  ex_op = 2'b00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    illegal_d     = illegal_q;
    bus_error_d   = bus_error_q;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    iord_c        = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    branch_c      = 1'b0;
    alu_src_1_c   = 1'b0;
    alu_src_2_c   = 1'b0;
    alu_op_c      = 2'b00;
    mem_to_reg_c  = 2'b00;
    reg_write_c   = 1'b0;
    next_pc_sel_c = 2'b00;
    retire_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        // mem_ready wins over an expiring wait counter in the same cycle
        if (mem_ready) begin
          ir_write_c = 1'b1;
          wait_d     = 8'd0;
          state_d    = S_DECODE;
        end else if (wait_q >= TIMEOUT_CNT) begin
          bus_error_d = 1'b1;
          state_d     = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        if (opcode_legal) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_EXECUTE: begin
        alu_src_1_c = ex_src_1;
        alu_src_2_c = ex_src_2;
        alu_op_c    = ex_op;
        if (is_load || is_store) begin
          wait_d  = 8'd0;
          state_d = S_MEM;
        end else if (is_branch) begin
          branch_c   = 1'b1;
          pc_write_c = 1'b1;
          retire_c   = 1'b1;
          wait_d     = 8'd0;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        alu_src_1_c = ex_src_1;
        alu_src_2_c = ex_src_2;
        alu_op_c    = ex_op;
        mem_req_c   = 1'b1;
        iord_c      = 1'b1;
        mem_we_c    = is_store;
        if (mem_ready) begin
          wait_d = 8'd0;
          if (is_store) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q >= TIMEOUT_CNT) begin
          bus_error_d = 1'b1;
          state_d     = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        reg_write_c   = 1'b1;
        pc_write_c    = 1'b1;
        retire_c      = 1'b1;
        mem_to_reg_c  = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b11 : 2'b00);
        next_pc_sel_c = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        wait_d        = 8'd0;
        state_d       = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opc_q       <= 7'd0;
      wait_q      <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      if (state_q == S_DECODE) begin
        opc_q <= opcode;
      end
    end
  end

  // Reset silences the bus immediately, even mid-transaction
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    alu_src_1   = 1'b0;
    alu_src_2   = 1'b0;
    alu_op      = 2'b00;
    mem_to_reg  = 2'b00;
    reg_write   = 1'b0;
    next_pc_sel = 2'b00;
    retire      = 1'b0;
    illegal     = 1'b0;
    bus_error   = 1'b0;
    state       = 3'd0;
    if (!rst) begin
      mem_req     = mem_req_c;
      mem_we      = mem_we_c;
      iord        = iord_c;
      ir_write    = ir_write_c;
      pc_write    = pc_write_c;
      branch      = branch_c;
      alu_src_1   = alu_src_1_c;
      alu_src_2   = alu_src_2_c;
      alu_op      = alu_op_c;
      mem_to_reg  = mem_to_reg_c;
      reg_write   = reg_write_c;
      next_pc_sel = next_pc_sel_c;
      retire      = retire_c;
      illegal     = illegal_q;
      bus_error   = bus_error_q;
      state       = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

  localparam int TO = 4;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       alu_src_1;
    logic       alu_src_2;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] next_pc_sel;
    logic       retire;
    logic       illegal;
    logic       bus_error;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, branch;
  logic       alu_src_1, alu_src_2, reg_write, retire, illegal, bus_error;
  logic [1:0] alu_op, mem_to_reg, next_pc_sel;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  vec_t obs;
  assign obs = {state, mem_req, mem_we, iord, ir_write, pc_write, branch,
                alu_src_1, alu_src_2, alu_op, mem_to_reg, reg_write,
                next_pc_sel, retire, illegal, bus_error};

  multicycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .alu_src_1(alu_src_1),
    .alu_src_2(alu_src_2), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .next_pc_sel(next_pc_sel), .retire(retire),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] legal_ops [9];

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // {alu_src_1, alu_src_2, alu_op} from the EXECUTE table
  function automatic logic [3:0] alu_attr(input logic [6:0] op);
    case (op)
      OP_R:              return 4'b0010;
      OP_I:              return 4'b0110;
      OP_LOAD, OP_STORE: return 4'b0100;
      OP_BR:             return 4'b0001;
      OP_JAL:            return 4'b0011;
      OP_JALR, OP_LUI:   return 4'b0111;
      OP_AUIPC:          return 4'b1111;
      default:           return 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic [6:0] op, input logic rdy, input logic rs,
                     input vec_t e, input string tag);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    rst       = rs;
    #1;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic do_reset();
    vec_t e;
    e = '0;
    cyc(junk(), coin(), 1'b1, e, "reset");
  endtask

  // One instruction: fw / mw are consecutive not-ready cycles in FETCH / MEM.
  // More than TO waits ends in a bus-error trap, and the task returns there.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    vec_t e;
    logic [3:0] a;
    bit ld, st, br;
    a  = alu_attr(op);
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    br = (op == OP_BR);

    for (int i = 0; i < fw && i <= TO; i++) begin
      e = '0; e.mem_req = 1'b1;
      cyc(junk(), 1'b0, 1'b0, e, "fetch_wait");
    end
    if (fw > TO) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.state = 3'd5; e.bus_error = 1'b1;
        cyc(junk(), coin(), 1'b0, e, "fetch_timeout_trap");
      end
      return;
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
    cyc(junk(), 1'b1, 1'b0, e, "fetch");

    e = '0; e.state = 3'd1;
    cyc(op, coin(), 1'b0, e, "decode");

    e = '0; e.state = 3'd2;
    {e.alu_src_1, e.alu_src_2, e.alu_op} = a;
    if (br) begin e.branch = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1; end
    cyc(junk(), coin(), 1'b0, e, "execute");

    if (ld || st) begin
      e = '0; e.state = 3'd3;
      {e.alu_src_1, e.alu_src_2, e.alu_op} = a;
      e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = st;
      for (int i = 0; i < mw && i <= TO; i++)
        cyc(junk(), 1'b0, 1'b0, e, "mem_wait");
      if (mw > TO) begin
        for (int i = 0; i < 3; i++) begin
          e = '0; e.state = 3'd5; e.bus_error = 1'b1;
          cyc(junk(), coin(), 1'b0, e, "mem_timeout_trap");
        end
        return;
      end
      if (st) begin e.pc_write = 1'b1; e.retire = 1'b1; end
      cyc(junk(), 1'b1, 1'b0, e, "mem_done");
    end

    if (!br && !st) begin
      e = '0; e.state = 3'd4;
      e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
      e.mem_to_reg  = ld ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b11 : 2'b00);
      e.next_pc_sel = (op == OP_JAL) ? 2'b01 : ((op == OP_JALR) ? 2'b10 : 2'b00);
      cyc(junk(), coin(), 1'b0, e, "writeback");
    end
  endtask

  task automatic run_illegal(input logic [6:0] op, input int hold);
    vec_t e;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
    cyc(junk(), 1'b1, 1'b0, e, "fetch");
    e = '0; e.state = 3'd1;
    cyc(op, coin(), 1'b0, e, "decode_illegal");
    e = '0; e.state = 3'd5; e.illegal = 1'b1;
    for (int i = 0; i < hold; i++)
      cyc(junk(), coin(), 1'b0, e, "illegal_trap");
  endtask

  initial begin
    vec_t e;
    logic [6:0] op;
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    rst       = 1'b1;
    opcode    = 7'd0;
    mem_ready = 1'b0;

    do_reset();
    do_reset();

    // Directed scenarios
    run_instr(OP_R, 0, 0);
    run_instr(OP_LOAD, 0, 3);
    run_instr(OP_STORE, 0, 2);
    run_instr(OP_BR, 0, 0);
    run_instr(OP_JAL, 1, 0);
    run_instr(OP_JALR, 0, 0);
    run_instr(OP_LUI, 0, 0);
    run_instr(OP_AUIPC, 2, 0);
    run_instr(OP_I, 0, 0);
    // Ready arrives on the same cycle the counter expires: no trap
    run_instr(OP_LOAD, TO, TO);
    run_instr(OP_STORE, TO, TO);

    // Randomized legal instruction stream
    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));
    end

    // Illegal opcode: sticky trap, cleared only by reset
    run_illegal(7'b0000000, 100);
    do_reset();
    run_instr(OP_R, 0, 0);
    for (int n = 0; n < 4; n++) begin
      do op = junk(); while (is_legal(op));
      run_illegal(op, 3);
      do_reset();
    end

    // FETCH timeout
    run_instr(OP_R, TO + 1, 0);
    do_reset();
    run_instr(OP_R, 0, 0);

    // MEM timeout
    run_instr(OP_LOAD, 0, TO + 1);
    do_reset();

    // Reset mid-MEM with mem_ready high: bus drops at once, then FETCH
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
    cyc(junk(), 1'b1, 1'b0, e, "fetch");
    e = '0; e.state = 3'd1;
    cyc(OP_LOAD, 1'b0, 1'b0, e, "decode");
    e = '0; e.state = 3'd2; e.alu_src_2 = 1'b1;
    cyc(junk(), 1'b0, 1'b0, e, "execute");
    e = '0; e.state = 3'd3; e.alu_src_2 = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1;
    cyc(junk(), 1'b0, 1'b0, e, "mem_wait");
    e = '0;
    cyc(junk(), 1'b1, 1'b1, e, "reset_mid_mem");
    e = '0; e.mem_req = 1'b1;
    cyc(junk(), 1'b0, 1'b0, e, "fetch_after_reset");
    run_instr(OP_STORE, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
